// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: extends the instruction immediate, precomputes PC + imm,
// and presents results through a 2-entry output/skid buffer with an illegal-format counter.
module imm_gen_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] PC,
    input  logic [2:0]            ImmSrc,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ImmOp,
    output logic [DATA_WIDTH-1:0] PCTarget,
    output logic                  ImmErr,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic [CNT_WIDTH-1:0]  ErrCount
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] imm_q, pct_q, skid_imm_q, skid_pct_q;
    logic                  err_q, skid_err_q;
    logic [TAG_WIDTH-1:0]  tag_q, skid_tag_q;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] imm_s, pct_s;
    logic                  err_s, accept_s, consume_s;
    logic                  unused_opcode_s;

    // The opcode field plays no part in immediate extraction.
    assign unused_opcode_s = ^instr[6:0];

    assign in_ready  = (state_q != TWO) & ~rst;
    assign out_valid = (state_q != EMPTY);
    assign accept_s  = in_valid & in_ready;
    assign consume_s = out_valid & out_ready;

    assign ImmOp    = imm_q;
    assign PCTarget = pct_q;
    assign ImmErr   = err_q;
    assign out_tag  = tag_q;
    assign ErrCount = cnt_q;

    // Immediate extraction: sign-extended formats start from all-copies of instr[31].
    always_comb begin
        imm_s = '0;
        err_s = 1'b0;
        case (ImmSrc)
            3'b000: begin
                imm_s        = {DATA_WIDTH{instr[31]}};
                imm_s[11:0]  = instr[31:20];
            end
            3'b001: begin
                imm_s        = {DATA_WIDTH{instr[31]}};
                imm_s[11:0]  = {instr[31:25], instr[11:7]};
            end
            3'b010: begin
                imm_s        = {DATA_WIDTH{instr[31]}};
                imm_s[12:0]  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            3'b011: begin
                imm_s        = {DATA_WIDTH{instr[31]}};
                imm_s[31:0]  = {instr[31:12], 12'b0};
            end
            3'b100: begin
                imm_s        = {DATA_WIDTH{instr[31]}};
                imm_s[20:0]  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            3'b101: begin
                if (DATA_WIDTH == 64) begin
                    imm_s[5:0] = instr[25:20];
                end else begin
                    imm_s[4:0] = instr[24:20];
                end
            end
            3'b110: begin
                imm_s[4:0]   = instr[19:15];
            end
            default: begin
                imm_s        = '0;
                err_s        = 1'b1;
            end
        endcase
    end

    assign pct_s = PC + imm_s;

    // Saturating count of accepted illegal-format requests.
    always_comb begin
        cnt_d = cnt_q;
        if (accept_s && err_s && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Buffer FSM: output register plus one skid entry, strictly in acceptance order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            imm_q      <= '0;
            pct_q      <= '0;
            err_q      <= 1'b0;
            tag_q      <= '0;
            skid_imm_q <= '0;
            skid_pct_q <= '0;
            skid_err_q <= 1'b0;
            skid_tag_q <= '0;
            cnt_q      <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                EMPTY: begin
                    if (accept_s) begin
                        imm_q   <= imm_s;
                        pct_q   <= pct_s;
                        err_q   <= err_s;
                        tag_q   <= in_tag;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (accept_s && consume_s) begin
                        imm_q   <= imm_s;
                        pct_q   <= pct_s;
                        err_q   <= err_s;
                        tag_q   <= in_tag;
                    end else if (accept_s) begin
                        skid_imm_q <= imm_s;
                        skid_pct_q <= pct_s;
                        skid_err_q <= err_s;
                        skid_tag_q <= in_tag;
                        state_q    <= TWO;
                    end else if (consume_s) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (consume_s) begin
                        imm_q   <= skid_imm_q;
                        pct_q   <= skid_pct_q;
                        err_q   <= skid_err_q;
                        tag_q   <= skid_tag_q;
                        state_q <= ONE;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage. It accepts a 32-bit instruction, PC and a 3-bit immediate-format select over a valid/ready handshake. It returns the extended immediate, a precomputed PC-relative target, and an illegal-format flag. A 2-entry skid buffer decouples decode from execute backpressure, and a saturating counter records illegal-format requests.

Parameters:
DATA_WIDTH, 32, datapath width (32 or 64); ImmOp, PC and PCTarget are this wide.
TAG_WIDTH, 5, width of the opaque sideband tag carried alongside each request (e.g. rd).
CNT_WIDTH, 8, width of the illegal-format counter.

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst  input  1  synchronous active-high reset.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request this cycle.
instr  input  32  instruction word.
PC  input  DATA_WIDTH  PC of instr.
ImmSrc  input  3  immediate format select.
in_tag  input  TAG_WIDTH  sideband, passed through unchanged.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
ImmOp  output  DATA_WIDTH  extended immediate.
PCTarget  output  DATA_WIDTH  PC + ImmOp, modulo 2^DATA_WIDTH.
ImmErr  output  1  ImmSrc was illegal (111).
out_tag  output  TAG_WIDTH  in_tag of the result.
ErrCount  output  CNT_WIDTH  illegal requests accepted since reset, saturating.

Behaviour:
- Clocking and reset:
  - One clock, clk. rst is synchronous and active-high.
  - While rst is high, in_ready=0.
  - Cycle after rst deasserts: in_ready=1, out_valid=0, ImmOp=0, PCTarget=0, ImmErr=0, out_tag=0, ErrCount=0.
- Format decode, where sext/zext extend to DATA_WIDTH:
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25],instr[11:7]}).
  - 010 B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - 011 U: sext({instr[31:12],12'b0}), i.e. upper bits are copies of instr[31] when DATA_WIDTH=64.
  - 100 J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - 101 SHAMT: zext(instr[24:20]) when DATA_WIDTH=32; zext(instr[25:20]) when DATA_WIDTH=64.
  - 110 ZIMM (CSR immediate): zext(instr[19:15]).
  - 111 illegal: ImmOp=0, PCTarget=PC, ImmErr=1.
- PCTarget is computed for every format; carry out is discarded.
- Handshake:
  - accept = in_valid & in_ready.
  - consume = out_valid & out_ready.
  - Latency is 1 cycle: a request accepted in cycle N is presented in cycle N+1 at the earliest.
- States:
  - EMPTY: output register empty.
  - ONE: output register valid, skid empty.
  - TWO: output and skid both valid.
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO) & !rst. in_ready is a function of registered state only, with no combinational path from out_ready.
- Transitions:
  - EMPTY: accept -> ONE, output register loaded.
  - ONE, accept & consume -> ONE, output register loaded with the new result.
  - ONE, accept & !consume -> TWO, skid loaded.
  - ONE, !accept & consume -> EMPTY.
  - TWO, consume -> ONE, output register <- skid. No accept is possible in TWO.
- Ordering and stability:
  - Results leave in strict acceptance order; none dropped, none duplicated.
  - While out_valid & !out_ready, all output fields hold stable.
- Inputs are sampled only on accept. Input values in non-accept cycles have no effect.
- ErrCount:
  - Increments by 1 on each accept with ImmSrc=111.
  - Holds at 2^CNT_WIDTH-1 (no wrap).
  - Counts at accept time, independent of consumption.
- Reset mid-operation: any state -> EMPTY; buffered results discarded; ErrCount cleared.

Test Plan:
- I-type, DATA_WIDTH=32: instr=0xFFF00093, ImmSrc=000, PC=0x0 accepted, out_ready=1 -> next cycle out_valid=1, ImmOp=0xFFFFFFFF, PCTarget=0xFFFFFFFF, ImmErr=0.
- B-type and J-type back-to-back, two consecutive accepts, out_ready=1:
  - instr=0xFE000EE3, ImmSrc=010, PC=0x100 -> ImmOp=0xFFFFFFFC, PCTarget=0x000000FC.
  - Then instr=0x0080006F, ImmSrc=100, PC=0x200 -> ImmOp=0x8, PCTarget=0x208, one result per cycle.
- U-type, DATA_WIDTH=64: instr=0x800000B7, ImmSrc=011 -> ImmOp=0xFFFFFFFF80000000. SHAMT with instr[25:20]=0x3F -> ImmOp=0x3F.
- Backpressure: out_ready=0, in_valid=1 with tags 1,2,3 offered -> tags 1,2 accepted, in_ready=0 from the cycle after the 2nd accept. Then out_ready=1 -> out_tag 1 then 2, values stable while stalled, then tag 3 accepted.
- Illegal and saturation, CNT_WIDTH=2: five accepts with ImmSrc=111, PC=0x40 -> each result ImmOp=0, PCTarget=0x40, ImmErr=1; ErrCount goes 1,2,3,3,3.
- Reset in state TWO: assert rst one cycle -> next cycle out_valid=0, ErrCount=0, all outputs 0. in_ready=0 during rst and 1 after.
